mem_target: RTL and testbench

- Parametrised synchronous memory target; successor to the single-cycle wr/addr/rddata memory model.
- Adds a valid/ready request channel and byte-enable writes.
- Adds a configurable read latency and an in-order response channel with backpressure.
- Flags out-of-range accesses with an error bit.
- Sits between a bus master (CPU model, DPI-driven) and storage in the same testbench/RTL hierarchy.

---
 rtl/mem_target_pkg.sv | 36 +++
 rtl/mem_target_rsp_fifo.sv | 68 ++++++
 rtl/mem_target.sv | 147 ++++++++++++++
 tb/tb_mem_target.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_target_pkg.sv
// mem_target_pkg: shared types and helpers for the mem_target memory block.
//   RD_LAT_MAX  - largest supported read latency.
//   RSP_DATA_W  - width of the response payload carried by rsp_t.
//   rsp_t       - one queued response {rdata, wr, err}.
//   merge()     - byte-lane merge of write data into an existing word.
package mem_target_pkg;

   localparam int unsigned RD_LAT_MAX = 4;
   localparam int unsigned RSP_DATA_W = 32;
   localparam int unsigned RSP_BE_W   = RSP_DATA_W / 8;

   typedef struct packed {
      logic [RSP_DATA_W-1:0] rdata;
      logic                  wr;
      logic                  err;
   } rsp_t;

   // Replace byte i of old_word with byte i of new_word wherever be[i] is set.
   function automatic logic [RSP_DATA_W-1:0] merge(
      input logic [RSP_DATA_W-1:0] old_word,
      input logic [RSP_DATA_W-1:0] new_word,
      input logic [RSP_BE_W-1:0]   be
   );
      logic [RSP_DATA_W-1:0] res;
      res = old_word;
      for (int i = 0; i < RSP_BE_W; i++) begin
         if (be[i]) begin
            res[8*i +: 8] = new_word[8*i +: 8];
         end else begin
            res[8*i +: 8] = old_word[8*i +: 8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/mem_target_rsp_fifo.sv
// mem_target_rsp_fifo: show-ahead FIFO of rsp_t entries.
//   clk, rst_n  - clock, asynchronous active-low reset.
//   push, push_data - write one entry (caller guarantees not full).
//   pop         - consume the head entry (ignored when empty).
//   valid, head - head entry present / head entry contents (zero when empty).
// An entry pushed into an empty FIFO is visible on head right after the push
// edge, so the FIFO adds no latency on top of the read pipeline.
module mem_target_rsp_fifo
   import mem_target_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  rsp_t push_data,
   input  logic pop,
   output logic valid,
   output rsp_t head
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   rsp_t             store [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return '0;
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   assign do_pop = pop && valid;
   assign valid  = (count != '0);
   assign head   = valid ? store[rd_ptr] : '0;

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            store[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            store[wr_ptr] <= push_data;
            wr_ptr        <= next_ptr(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mem_target.sv
// mem_target: word-addressed memory target with a valid/ready request channel,
// byte-enable writes, fixed read latency and an in-order response channel.
//   clk, rst_n                         - clock, asynchronous active-low reset.
//   req_valid/req_ready                - request handshake.
//   req_wr, req_addr, req_wdata, req_be - request payload.
//   rsp_valid/rsp_ready                - response handshake.
//   rsp_rdata, rsp_wr, rsp_err         - response payload (rdata is 0 for
//                                        writes and out-of-range accesses).
// The response is formed at the accepting edge, delayed RD_LAT-1 edges in a
// shift pipeline, then parked in a show-ahead FIFO until the master takes it.
// The outstanding counter covers pipeline plus FIFO, so the FIFO never overflows.
module mem_target
   import mem_target_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned DEPTH     = 16,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned RD_LAT    = 2,
   parameter int unsigned RSP_DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_wr,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_wr,
   output logic                rsp_err
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

   // Elaboration-time parameter checks.
   if ((DATA_W % 8 != 0) || (DATA_W != RSP_DATA_W)) begin : g_bad_data_w
      $error("mem_target: DATA_W must be a multiple of 8 and match RSP_DATA_W");
   end
   if ((RD_LAT < 1) || (RD_LAT > RD_LAT_MAX)) begin : g_bad_rd_lat
      $error("mem_target: RD_LAT out of range 1..RD_LAT_MAX");
   end
   if (RSP_DEPTH < RD_LAT) begin : g_bad_rsp_depth
      $error("mem_target: RSP_DEPTH must be >= RD_LAT");
   end

   logic [DATA_W-1:0] mem [DEPTH];
   logic [CNT_W-1:0]  outstanding;
   logic              accept;
   logic              complete;
   logic              in_range;
   logic [IDX_W-1:0]  idx;
   rsp_t              new_rsp;
   logic              push;
   rsp_t              push_data;
   logic              head_valid;
   rsp_t              head;

   assign req_ready = (outstanding < CNT_W'(RSP_DEPTH));
   assign accept    = req_valid && req_ready;
   assign complete  = head_valid && rsp_ready;
   // Range check on the full address; idx is only used when in_range holds,
   // so high address bits can never alias onto a valid word.
   assign in_range  = (req_addr < ADDR_W'(DEPTH));
   assign idx       = req_addr[IDX_W-1:0];

   // Response payload captured at the accepting edge.
   always_comb begin
      new_rsp     = '0;
      new_rsp.wr  = req_wr;
      new_rsp.err = !in_range;
      if (!req_wr && in_range) begin
         new_rsp.rdata = mem[idx];
      end else begin
         new_rsp.rdata = '0;
      end
   end

   // Storage array: deliberately not reset, contents survive rst_n.
   always_ff @(posedge clk) begin
      if (accept && req_wr && in_range) begin
         mem[idx] <= merge(mem[idx], req_wdata, req_be);
      end
   end

   // Outstanding requests: accepted but not yet completed on the response side.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding <= '0;
      end else begin
         case ({accept, complete})
            2'b10:   outstanding <= outstanding + CNT_W'(1);
            2'b01:   outstanding <= outstanding - CNT_W'(1);
            default: outstanding <= outstanding;
         endcase
      end
   end

   if (RD_LAT == 1) begin : g_no_pipe
      assign push      = accept;
      assign push_data = new_rsp;
   end else begin : g_pipe
      logic [RD_LAT-2:0] pipe_valid;
      rsp_t              pipe_data [RD_LAT-1];

      // Fixed-latency shift pipeline ahead of the response FIFO.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            pipe_valid <= '0;
            for (int i = 0; i < RD_LAT - 1; i++) begin
               pipe_data[i] <= '0;
            end
         end else begin
            pipe_valid[0] <= accept;
            pipe_data[0]  <= new_rsp;
            for (int i = 1; i < RD_LAT - 1; i++) begin
               pipe_valid[i] <= pipe_valid[i-1];
               pipe_data[i]  <= pipe_data[i-1];
            end
         end
      end

      assign push      = pipe_valid[RD_LAT-2];
      assign push_data = pipe_data[RD_LAT-2];
   end

   mem_target_rsp_fifo #(
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_data),
      .pop       (complete),
      .valid     (head_valid),
      .head      (head)
   );

   assign rsp_valid = head_valid;
   assign rsp_rdata = head.rdata;
   assign rsp_wr    = head.wr;
   assign rsp_err   = head.err;

endmodule

// File: tb/tb_mem_target.sv
// tb_mem_target: self-checking bench for mem_target (default parameters).
// Reference model: a word array plus a queue of expected responses, each
// tagged with the edge number from which it may be visible. The head of the
// queue must be on rsp_* exactly when its visibility edge has passed.
module tb_mem_target;

   localparam int DATA_W    = 32;
   localparam int DEPTH     = 16;
   localparam int ADDR_W    = 32;
   localparam int RD_LAT    = 2;
   localparam int RSP_DEPTH = 4;

   logic              clk;
   logic              rst_n;
   logic              req_valid;
   logic              req_ready;
   logic              req_wr;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [3:0]        req_be;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_wr;
   logic              rsp_err;

   mem_target #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .ADDR_W    (ADDR_W),
      .RD_LAT    (RD_LAT),
      .RSP_DEPTH (RSP_DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_wr    (rsp_wr),
      .rsp_err   (rsp_err)
   );

   typedef struct {
      logic [31:0] rdata;
      bit          wr;
      bit          err;
      int          ready_at;
   } exp_t;

   exp_t        q[$];
   logic [31:0] mdl [DEPTH];
   logic [31:0] fill_data [DEPTH];
   int          edge_n;
   int          checks;
   int          failures;
   logic [31:0] last_rdata;
   logic        last_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge_m(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) begin
         if (b[i]) r[8*i +: 8] = n[8*i +: 8];
      end
      return r;
   endfunction

   // One clock cycle: called at a negedge with inputs already driven.
   task automatic step(output bit acc);
      bit          exp_v;
      bit          exp_rdy;
      bit          cmp;
      logic        wr_s;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  b;
      exp_rdy = (q.size() < RSP_DEPTH);
      exp_v   = 1'b0;
      if (q.size() > 0) begin
         if (q[0].ready_at <= edge_n) exp_v = 1'b1;
      end
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
      if (exp_v) begin
         chk("rsp_rdata", rsp_rdata, q[0].rdata);
         chk("rsp_wr", 32'(rsp_wr), 32'(q[0].wr));
         chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
      end
      acc = req_valid && exp_rdy;
      cmp = exp_v && rsp_ready;
      if (cmp) begin
         last_rdata = rsp_rdata;
         last_err   = rsp_err;
      end
      wr_s = req_wr;
      a    = req_addr;
      d    = req_wdata;
      b    = req_be;
      @(posedge clk);
      edge_n++;
      if (cmp) void'(q.pop_front());
      if (acc) begin
         exp_t e;
         e.wr       = wr_s;
         e.err      = (a >= 32'(DEPTH));
         e.rdata    = 32'h0;
         e.ready_at = edge_n + RD_LAT - 1;
         if (!e.err) begin
            if (wr_s) mdl[a[3:0]] = merge_m(mdl[a[3:0]], d, b);
            else      e.rdata = mdl[a[3:0]];
         end
         q.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
      bit acc;
      int n;
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = a;
      req_wdata = d;
      req_be    = b;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 50) begin
         step(acc);
         n++;
      end
      req_valid = 1'b0;
      checks++;
      assert (acc) else begin
         failures++;
         $error("FAIL issue_timeout observed=not_accepted expected=accepted addr=%h", a);
      end
   endtask

   task automatic drain();
      bit acc;
      int n;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      n = 0;
      while (q.size() > 0 && n < 50) begin
         step(acc);
         n++;
      end
      checks++;
      assert (q.size() == 0) else begin
         failures++;
         $error("FAIL drain_timeout observed=%0d pending expected=0", q.size());
      end
   endtask

   initial begin
      bit acc;
      int i;
      checks     = 0;
      failures   = 0;
      edge_n     = 0;
      last_rdata = 32'h0;
      last_err   = 1'b0;
      rst_n      = 1'b0;
      req_valid  = 1'b1;
      req_wr     = 1'b0;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      req_be     = 4'h0;
      rsp_ready  = 1'b1;

      // Reset held across 3 edges with a request pending.
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
         @(posedge clk);
         edge_n++;
      end
      @(negedge clk);
      rst_n     = 1'b1;
      req_valid = 1'b0;
      chk("reset_req_ready", 32'(req_ready), 32'h1);
      for (int k = 0; k < 4; k++) step(acc);

      // Fill every word with known data.
      for (int k = 0; k < DEPTH; k++) begin
         fill_data[k] = $urandom;
         issue(1'b1, 32'(k), fill_data[k], 4'hF);
      end
      drain();

      // Write then read back-to-back, byte enables.
      issue(1'b1, 32'd3, 32'hDEADBEEF, 4'hF);
      issue(1'b0, 32'd3, 32'h0, 4'h0);
      drain();
      chk("rd_after_wr", last_rdata, 32'hDEADBEEF);
      issue(1'b1, 32'd3, 32'h11223344, 4'b0101);
      issue(1'b0, 32'd3, 32'h0, 4'h0);
      drain();
      chk("be_0101", last_rdata, 32'hDE22BE44);
      issue(1'b1, 32'd3, 32'hFFFFFFFF, 4'h0);
      issue(1'b0, 32'd3, 32'h0, 4'h0);
      drain();
      chk("be_zero", last_rdata, 32'hDE22BE44);

      // Out of range.
      issue(1'b0, 32'd16, 32'h0, 4'h0);
      drain();
      chk("oor_err", 32'(last_err), 32'h1);
      chk("oor_rdata", last_rdata, 32'h0);
      issue(1'b1, 32'd20, 32'hFFFFFFFF, 4'hF);
      issue(1'b0, 32'd4, 32'h0, 4'h0);
      drain();
      chk("oor_wr_dropped", last_rdata, fill_data[4]);
      chk("oor_wr_err", 32'(last_err), 32'h0);

      // Backpressure: only RSP_DEPTH requests may be outstanding.
      rsp_ready = 1'b0;
      i = 0;
      for (int c = 0; c < 10; c++) begin
         req_valid = 1'b1;
         req_wr    = 1'b0;
         req_addr  = 32'(i);
         step(acc);
         if (acc) i++;
      end
      chk("bp_accepted", 32'(i), 32'd4);
      chk("bp_req_ready", 32'(req_ready), 32'h0);
      rsp_ready = 1'b1;
      for (int c = 0; c < 20 && i < 6; c++) begin
         req_addr = 32'(i);
         step(acc);
         if (acc) i++;
      end
      req_valid = 1'b0;
      chk("bp_all_accepted", 32'(i), 32'd6);
      drain();
      chk("bp_last_rdata", last_rdata, mdl[5]);

      // Randomized traffic with random response backpressure.
      for (int c = 0; c < 300; c++) begin
         req_valid = 1'($urandom_range(0, 1));
         req_wr    = 1'($urandom_range(0, 1));
         req_addr  = 32'($urandom_range(0, 19));
         req_wdata = $urandom;
         req_be    = 4'($urandom_range(0, 15));
         rsp_ready = ($urandom_range(0, 3) != 0);
         step(acc);
      end
      drain();

      // Reset in the middle of two outstanding reads.
      issue(1'b1, 32'd7, 32'hCAFEF00D, 4'hF);
      drain();
      rsp_ready = 1'b0;
      issue(1'b0, 32'd3, 32'h0, 4'h0);
      issue(1'b0, 32'd5, 32'h0, 4'h0);
      chk("midrst_pre_valid", 32'(rsp_valid), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_async_valid", 32'(rsp_valid), 32'h0);
      q.delete();
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      for (int k = 0; k < 6; k++) step(acc);
      issue(1'b0, 32'd7, 32'h0, 4'h0);
      drain();
      chk("midrst_persist", last_rdata, 32'hCAFEF00D);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
